// File: rtl/hero_game_ctrl.sv
// Game-flow sequencer for H.E.R.O.: part selection, lives, death/rescue handling and bomb fuse.
// Build option HERO_BONUS_LIFE_EN: each completed non-final part awards one life (saturating at 7).
module hero_game_ctrl #(
  parameter int NUM_PARTS    = 2,
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int DONE_FRAMES  = 90,
  parameter int BOMB_FRAMES  = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 start_key,
  input  logic                 f_key,
  input  logic                 death,
  input  logic                 coll_miner,
  input  logic [9:0]           char_pos_x,
  input  logic [9:0]           char_pos_y,
  output logic [NUM_PARTS-1:0] part_sel,
  output logic                 level_enable,
  output logic [2:0]           lives,
  output logic [3:0]           b_cnt,
  output logic [9:0]           bomb_pos_x,
  output logic [9:0]           bomb_pos_y,
  output logic                 respawn,
  output logic                 game_over,
  output logic                 win,
  output logic [2:0]           state
);
  // state      | meaning
  // IDLE       | waiting for the first start press
  // PLAY       | active part rendered and playable
  // DYING      | death animation, frame timer running
  // LEVEL_DONE | miner rescued, frame timer running
  // GAME_OVER  | no lives left, start returns to IDLE
  // WIN        | last part completed, start returns to IDLE
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PLAY       = 3'd1,
    S_DYING      = 3'd2,
    S_LEVEL_DONE = 3'd3,
    S_GAME_OVER  = 3'd4,
    S_WIN        = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, f_q, start_edge, f_edge;
  logic [2:0] part_idx, part_idx_d, lives_d;
  logic [7:0] frm_cnt, frm_cnt_d, bomb_cnt;
  logic       respawn_d;

  assign start_edge   = start_key & ~start_q;
  assign f_edge       = f_key & ~f_q;
  assign state        = state_q;
  assign level_enable = (state_q == S_PLAY);
  assign game_over    = (state_q == S_GAME_OVER);
  assign win          = (state_q == S_WIN);
  assign part_sel     = NUM_PARTS'(1) << part_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      part_idx <= 3'd0;
      lives    <= 3'(LIVES_INIT);
      frm_cnt  <= 8'd0;
      respawn  <= 1'b0;
      start_q  <= 1'b0;
      f_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      part_idx <= part_idx_d;
      lives    <= lives_d;
      frm_cnt  <= frm_cnt_d;
      respawn  <= respawn_d;
      start_q  <= start_key;
      f_q      <= f_key;
    end
  end

  always_comb begin
    state_d    = state_q;
    part_idx_d = part_idx;
    lives_d    = lives;
    frm_cnt_d  = frm_cnt;
    respawn_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_PLAY;
          lives_d    = 3'(LIVES_INIT);
          part_idx_d = 3'd0;
          respawn_d  = 1'b1;
        end
      end
      S_PLAY: begin
        // death has priority over a simultaneous rescue
        if (death) begin
          state_d   = S_DYING;
          lives_d   = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
          frm_cnt_d = 8'd0;
        end else if (coll_miner) begin
          state_d   = S_LEVEL_DONE;
          frm_cnt_d = 8'd0;
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (frm_cnt == 8'(DEATH_FRAMES - 1)) begin
            frm_cnt_d = 8'd0;
            if (lives == 3'd0) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d   = S_PLAY;
              respawn_d = 1'b1;
            end
          end else begin
            frm_cnt_d = frm_cnt + 8'd1;
          end
        end
      end
      S_LEVEL_DONE: begin
        if (frame_tick) begin
          if (frm_cnt == 8'(DONE_FRAMES - 1)) begin
            frm_cnt_d = 8'd0;
            if (part_idx == 3'(NUM_PARTS - 1)) begin
              state_d = S_WIN;
            end else begin
              state_d    = S_PLAY;
              part_idx_d = part_idx + 3'd1;
              respawn_d  = 1'b1;
`ifdef HERO_BONUS_LIFE_EN
              if (lives != 3'd7) lives_d = lives + 3'd1;
`else
              lives_d = lives;
`endif
            end
          end else begin
            frm_cnt_d = frm_cnt + 8'd1;
          end
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (start_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bomb fuse runs only in PLAY; position stays latched after the fuse clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_cnt      <= 4'd0;
      bomb_cnt   <= 8'd0;
      bomb_pos_x <= 10'd0;
      bomb_pos_y <= 10'd0;
    end else if (state_q != S_PLAY) begin
      b_cnt    <= 4'd0;
      bomb_cnt <= 8'd0;
    end else if (f_edge && (b_cnt == 4'd0)) begin
      b_cnt      <= 4'd1;
      bomb_cnt   <= 8'd0;
      bomb_pos_x <= char_pos_x;
      bomb_pos_y <= char_pos_y;
    end else if ((b_cnt != 4'd0) && frame_tick) begin
      if (bomb_cnt == 8'(BOMB_FRAMES - 1)) begin
        bomb_cnt <= 8'd0;
        b_cnt    <= (b_cnt == 4'd3) ? 4'd0 : b_cnt + 4'd1;
      end else begin
        bomb_cnt <= bomb_cnt + 8'd1;
      end
    end
  end

endmodule
